// File: rtl/i2c_host_ctrl.sv
// Single-byte I2C bus master: START, address+rw, one data byte, ACK/NACK, STOP.
// Define I2C_STRETCH_EN to let the target hold SCL low during Q2 (clock stretching).
module i2c_host_ctrl #(
  parameter int unsigned QTR   = 25,
  parameter int unsigned QTR_W = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i,
  input  logic       scl_i
);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAack, StWdata, StWack, StRdata, StMnack, StStop, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [QTR_W-1:0]   qcnt_q, qcnt_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               rw_q, rw_d;
  logic               ack_q, ack_d;
  logic               nack_q, nack_d;
  logic               scl_q, scl_d;
  logic               sda_q, sda_d;
  logic               slot_end;
  logic               hold;

  // Pin levels for a given state/quarter; applied to next-state values so the
  // pins come straight from flops.
  function automatic logic [1:0] bus_drive(state_e st, logic [1:0] qtr, logic txb);
    logic [1:0] drv;
    case (st)
      StStart:                          drv = {1'b1, ~qtr[1]};
      StAddr, StWdata:                  drv = {qtr[1], txb};
      StAack, StWack, StRdata, StMnack: drv = {qtr[1], 1'b1};
      StStop:                           drv = {qtr != 2'd0, qtr == 2'd3};
      default:                          drv = 2'b11;
    endcase
    return drv;
  endfunction

`ifndef I2C_STRETCH_EN
  logic unused_scl;
  assign unused_scl = scl_i;
`endif

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    nack_d   = nack_q;
    slot_end = 1'b0;
    hold     = 1'b0;
`ifdef I2C_STRETCH_EN
    hold = (qtr_q == 2'd2) && !scl_i;
`endif
    if (state_q == StIdle) begin
      if (cmd_valid) begin
        state_d = StStart;
        tx_d    = {cmd_addr, cmd_rw};
        rw_d    = cmd_rw;
        wdata_d = cmd_wdata;
        nack_d  = 1'b0;
        qcnt_d  = '0;
        qtr_d   = 2'd0;
        bit_d   = 3'd0;
      end
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end else begin
      // Stretching keeps Q2 restarting until SCL is actually seen high.
      if (hold) begin
        qcnt_d = '0;
      end else if (qcnt_q == QTR_W'(QTR - 1)) begin
        qcnt_d   = '0;
        qtr_d    = qtr_q + 2'd1;
        slot_end = (qtr_q == 2'd3);
      end else begin
        qcnt_d = qcnt_q + 1'b1;
      end

      if ((qtr_q == 2'd3) && (qcnt_q == '0)) begin
        ack_d = sda_i;
        if (state_q == StRdata) rx_d = {rx_q[6:0], sda_i};
      end

      if (slot_end) begin
        case (state_q)
          StStart: state_d = StAddr;
          StAddr: begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAack;
          end
          StAack: begin
            if (ack_q) begin
              nack_d  = 1'b1;
              state_d = StStop;
            end else if (rw_q) begin
              state_d = StRdata;
            end else begin
              state_d = StWdata;
              tx_d    = wdata_q;
            end
          end
          StWdata: begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StWack;
          end
          StWack: begin
            nack_d  = ack_q;
            state_d = StStop;
          end
          StRdata: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StMnack;
          end
          StMnack: begin
            rdata_d = rx_q;
            state_d = StStop;
          end
          StStop:  state_d = StDone;
          default: state_d = StIdle;
        endcase
      end
    end
    {scl_d, sda_d} = bus_drive(state_d, qtr_d, tx_d[7]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      qcnt_q  <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      ack_q   <= 1'b1;
      nack_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;

endmodule

// File: tb/tb_i2c_host_ctrl.sv
// Bench for i2c_host_ctrl: behavioural I2C target on the pins plus a transaction-level
// model of latency, NACK and read-data results.
module tb_i2c_host_ctrl;

  localparam int QTR = 25;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = 7'h00;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       scl_o, sda_o, sda_i, scl_i;
  logic       stretch = 1'b0;

  // Target configuration and observations
  logic       tgt_present = 1'b1;
  logic       tgt_dack = 1'b1;
  logic [7:0] tgt_rbyte = 8'h00;
  logic       tgt_sda = 1'b1;
  int         n_starts = 0, n_stops = 0, n_wbytes = 0;
  logic [7:0] last_addr_byte = 8'h00, last_wbyte = 8'h00;
  logic       last_mnack = 1'b0;
  logic       t_prev_scl = 1'b1, t_prev_sda = 1'b1;
  int         t_nbits = 0, t_phase = 0;
  logic [7:0] t_sh = 8'h00;

  int         cyc = 0;
  int         n_checks = 0, n_errors = 0;
  logic [7:0] rdata_model = 8'h00;

  assign sda_i = sda_o & tgt_sda;
  assign scl_i = scl_o & ~stretch;

  i2c_host_ctrl #(.QTR(QTR), .QTR_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .scl_o(scl_o), .sda_o(sda_o),
    .sda_i(sda_i), .scl_i(scl_i)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Target: phases 0 idle, 1 address, 2 write data, 3 read data, 4 finished.
  always @(negedge clock) begin
    if (!reset_n) begin
      tgt_sda <= 1'b1; t_phase <= 0; t_nbits <= 0; t_prev_scl <= 1'b1; t_prev_sda <= 1'b1;
    end else begin
      t_prev_scl <= scl_o;
      t_prev_sda <= sda_o;
      if (scl_o && t_prev_scl && t_prev_sda && !sda_o) begin
        n_starts <= n_starts + 1; t_phase <= 1; t_nbits <= 0; tgt_sda <= 1'b1;
      end else if (scl_o && t_prev_scl && !t_prev_sda && sda_o) begin
        n_stops <= n_stops + 1; t_phase <= 0; tgt_sda <= 1'b1;
      end else if (scl_o && !t_prev_scl) begin
        if (t_nbits < 8) begin
          t_sh <= {t_sh[6:0], sda_o};
          if (t_nbits == 7 && t_phase == 1) last_addr_byte <= {t_sh[6:0], sda_o};
          if (t_nbits == 7 && t_phase == 2) begin
            last_wbyte <= {t_sh[6:0], sda_o};
            n_wbytes   <= n_wbytes + 1;
          end
        end else if (t_nbits == 8 && t_phase == 3) begin
          last_mnack <= sda_o;
        end
        t_nbits <= t_nbits + 1;
      end else if (!scl_o && t_prev_scl && t_phase != 0) begin
        if (t_nbits == 8) begin
          if (t_phase == 1)      tgt_sda <= ~tgt_present;
          else if (t_phase == 2) tgt_sda <= ~tgt_dack;
          else                   tgt_sda <= 1'b1;
        end else if (t_nbits == 9) begin
          t_nbits <= 0;
          if (t_phase == 1 && tgt_present && last_addr_byte[0]) begin
            t_phase <= 3; tgt_sda <= tgt_rbyte[7];
          end else if (t_phase == 1 && tgt_present) begin
            t_phase <= 2; tgt_sda <= 1'b1;
          end else begin
            t_phase <= 4; tgt_sda <= 1'b1;
          end
        end else if (t_phase == 3 && t_nbits >= 1 && t_nbits <= 7) begin
          tgt_sda <= tgt_rbyte[7 - t_nbits];
        end
      end
    end
  end

  // Drives one command from a negedge and returns at the negedge where rsp_valid is seen.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                         input logic present, input logic dack, input logic [7:0] rbyte,
                         input bit hold, input int stretch_rise,
                         output int acc_cyc, output int rsp_cyc, output int ready_glitch);
    int   nrise, left;
    logic prev;
    tgt_present = present; tgt_dack = dack; tgt_rbyte = rbyte;
    cmd_addr = addr; cmd_rw = rw; cmd_wdata = wdata; cmd_valid = 1'b1;
    acc_cyc = -1; rsp_cyc = -1; ready_glitch = 0; nrise = 0; left = 0;
    for (int i = 0; i < 100 && acc_cyc < 0; i++) begin
      if (cmd_ready) acc_cyc = cyc;
      else @(negedge clock);
    end
    if (acc_cyc < 0) return;
    prev = scl_o;
    for (int i = 0; i < 6000 && rsp_cyc < 0; i++) begin
      @(negedge clock);
      if (!hold) cmd_valid = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) stretch = 1'b0;
      end
      if (scl_o && !prev) begin
        nrise++;
        if (nrise == stretch_rise) begin
          stretch = 1'b1; left = 300;
        end
      end
      prev = scl_o;
      if (rsp_valid) rsp_cyc = cyc;
      else if (cmd_ready) ready_glitch++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks += 6;
    if (scl_o !== 1'b1) begin n_errors++; $display("FAIL reset_scl: got %b want 1", scl_o); end
    if (sda_o !== 1'b1) begin n_errors++; $display("FAIL reset_sda: got %b want 1", sda_o); end
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
    if (rsp_nack !== 1'b0) begin n_errors++; $display("FAIL reset_nack: got %b want 0", rsp_nack); end
    reset_n = 1'b1;
    rdata_model = 8'h00;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_write;
    int a, r, g, s0, p0, w0;
    s0 = n_starts; p0 = n_stops; w0 = n_wbytes;
    run_txn(7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 0, a, r, g);
    n_checks += 6;
    if (r - a !== 2001) begin n_errors++; $display("FAIL wr_latency: got %0d want 2001", r - a); end
    if (last_addr_byte !== 8'h54) begin n_errors++; $display("FAIL wr_addr_byte: got %h want 54", last_addr_byte); end
    if (last_wbyte !== 8'hA5 || n_wbytes - w0 !== 1) begin
      n_errors++; $display("FAIL wr_data_byte: got %h x%0d want a5 x1", last_wbyte, n_wbytes - w0);
    end
    if (rsp_nack !== 1'b0) begin n_errors++; $display("FAIL wr_nack: got %b want 0", rsp_nack); end
    if (n_starts - s0 !== 1 || n_stops - p0 !== 1) begin
      n_errors++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", n_starts - s0, n_stops - p0);
    end
    if (g !== 0) begin n_errors++; $display("FAIL wr_ready_busy: got %0d want 0", g); end
    @(negedge clock);
  endtask

  task automatic test_read;
    int a, r, g;
    run_txn(7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 0, a, r, g);
    rdata_model = 8'h3C;
    n_checks += 5;
    if (r - a !== 2001) begin n_errors++; $display("FAIL rd_latency: got %0d want 2001", r - a); end
    if (last_addr_byte !== 8'h55) begin n_errors++; $display("FAIL rd_addr_byte: got %h want 55", last_addr_byte); end
    if (last_mnack !== 1'b1) begin n_errors++; $display("FAIL rd_master_nack: got %b want 1", last_mnack); end
    if (rsp_rdata !== rdata_model) begin n_errors++; $display("FAIL rd_data: got %h want %h", rsp_rdata, rdata_model); end
    if (rsp_nack !== 1'b0) begin n_errors++; $display("FAIL rd_nack: got %b want 0", rsp_nack); end
    @(negedge clock);
  endtask

  task automatic test_addr_nack;
    int a, r, g, w0, p0;
    w0 = n_wbytes; p0 = n_stops;
    run_txn(7'h11, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 0, a, r, g);
    n_checks += 4;
    if (r - a !== 1101) begin n_errors++; $display("FAIL an_latency: got %0d want 1101", r - a); end
    if (rsp_nack !== 1'b1) begin n_errors++; $display("FAIL an_nack: got %b want 1", rsp_nack); end
    if (n_wbytes - w0 !== 0) begin n_errors++; $display("FAIL an_no_data: got %0d want 0", n_wbytes - w0); end
    if (n_stops - p0 !== 1) begin n_errors++; $display("FAIL an_stop: got %0d want 1", n_stops - p0); end
    @(negedge clock);
    n_checks++;
    if (rsp_nack !== 1'b1) begin n_errors++; $display("FAIL an_nack_hold: got %b want 1", rsp_nack); end
  endtask

  task automatic test_back_to_back;
    int a1, r1, g1, a2, r2, g2, w0;
    w0 = n_wbytes;
    run_txn(7'h2A, 1'b0, 8'h11, 1'b1, 1'b1, 8'h00, 1'b1, 0, a1, r1, g1);
    n_checks += 2;
    if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_done_ready: got %b want 0", cmd_ready); end
    if (g1 !== 0) begin n_errors++; $display("FAIL b2b_ready_busy1: got %0d want 0", g1); end
    run_txn(7'h2A, 1'b0, 8'h22, 1'b1, 1'b1, 8'h00, 1'b0, 0, a2, r2, g2);
    n_checks += 5;
    if (a2 - r1 !== 1) begin n_errors++; $display("FAIL b2b_accept_gap: got %0d want 1", a2 - r1); end
    if (r1 - a1 !== 2001 || r2 - a2 !== 2001) begin
      n_errors++; $display("FAIL b2b_latency: got %0d/%0d want 2001/2001", r1 - a1, r2 - a2);
    end
    if (g2 !== 0) begin n_errors++; $display("FAIL b2b_ready_busy2: got %0d want 0", g2); end
    if (n_wbytes - w0 !== 2) begin n_errors++; $display("FAIL b2b_bytes: got %0d want 2", n_wbytes - w0); end
    if (last_wbyte !== 8'h22) begin n_errors++; $display("FAIL b2b_data2: got %h want 22", last_wbyte); end
    @(negedge clock);
  endtask

  task automatic test_random;
    int a, r, g, s0, p0, w0, exp_lat;
    logic [6:0] addr;
    logic [7:0] wd, rb;
    logic rw, pres, dack, exp_nack;
    for (int k = 0; k < 6; k++) begin
      addr = 7'($urandom_range(0, 127));
      wd   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rw   = 1'($urandom_range(0, 1));
      pres = ($urandom_range(0, 3) != 0);
      dack = ($urandom_range(0, 3) != 0);
      s0 = n_starts; p0 = n_stops; w0 = n_wbytes;
      run_txn(addr, rw, wd, pres, dack, rb, 1'b0, 0, a, r, g);
      exp_nack = !pres || (!rw && !dack);
      exp_lat  = QTR * (pres ? 80 : 44) + 1;
      if (rw && pres) rdata_model = rb;
      n_checks += 7;
      if (r - a !== exp_lat) begin n_errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, r - a, exp_lat); end
      if (rsp_nack !== exp_nack) begin n_errors++; $display("FAIL rnd%0d_nack: got %b want %b", k, rsp_nack, exp_nack); end
      if (rsp_rdata !== rdata_model) begin n_errors++; $display("FAIL rnd%0d_rdata: got %h want %h", k, rsp_rdata, rdata_model); end
      if (last_addr_byte !== {addr, rw}) begin
        n_errors++; $display("FAIL rnd%0d_addr_byte: got %h want %h", k, last_addr_byte, {addr, rw});
      end
      if (n_wbytes - w0 !== ((!rw && pres) ? 1 : 0) || (!rw && pres && last_wbyte !== wd)) begin
        n_errors++; $display("FAIL rnd%0d_wdata: got %h x%0d want %h", k, last_wbyte, n_wbytes - w0, wd);
      end
      if (n_starts - s0 !== 1 || n_stops - p0 !== 1) begin
        n_errors++; $display("FAIL rnd%0d_start_stop: got %0d/%0d want 1/1", k, n_starts - s0, n_stops - p0);
      end
      @(negedge clock);
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        n_errors++; $display("FAIL rnd%0d_pulse: got rsp %b ready %b want 0 1", k, rsp_valid, cmd_ready);
      end
    end
  endtask

`ifdef I2C_STRETCH_EN
  task automatic test_stretch;
    int a, r, g;
    // Rise 14 = 8 address bits + address ACK + data bits 7..3.
    run_txn(7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0, 14, a, r, g);
    n_checks += 2;
    if (r - a !== 2301) begin n_errors++; $display("FAIL st_latency: got %0d want 2301", r - a); end
    if (last_wbyte !== 8'hC3) begin n_errors++; $display("FAIL st_data: got %h want c3", last_wbyte); end
    @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid;
    int seen;
    tgt_present = 1'b1; tgt_dack = 1'b1;
    cmd_addr = 7'h33; cmd_rw = 1'b0; cmd_wdata = 8'h0F; cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (53 * QTR + QTR / 2) @(negedge clock);
    n_checks += 2;
    if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %b want 0", cmd_ready); end
    if (scl_o !== 1'b0) begin n_errors++; $display("FAIL rm_mid_scl: got %b want 0", scl_o); end
    #2 reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (scl_o !== 1'b1 || sda_o !== 1'b1) begin
      n_errors++; $display("FAIL rm_release: got scl %b sda %b want 1 1", scl_o, sda_o);
    end
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rm_rsp: got %b want 0", rsp_valid); end
    @(negedge clock);
    reset_n = 1'b1;
    rdata_model = 8'h00;
    seen = 0;
    repeat (2500) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    n_checks += 2;
    if (seen !== 0) begin n_errors++; $display("FAIL rm_no_rsp: got %0d want 0", seen); end
    if (rsp_rdata !== rdata_model) begin n_errors++; $display("FAIL rm_rdata: got %h want %h", rsp_rdata, rdata_model); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_random();
`ifdef I2C_STRETCH_EN
    test_stretch();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
